dm_responder: RTL and testbench

- Data-memory responder serving the processor's data-memory port: the processor drives address (AR), write data (bus) and write enable (dm_en); this block returns read data (dm_out) and the 2-bit status.
- Also owns a host port used to preload matrix operands before a run and read results back afterwards.
- Holds the data RAM and a small run-control FSM that tracks start and end_process and arbitrates between host and processor.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_responder_if.sv | 40 ++++
 rtl/dm_ram.sv | 48 ++++
 rtl/dm_responder.sv | 145 ++++++++++++++
 tb/tb_dm_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_e      : run-control FSM states (IDLE, RUN, DONE)
//   STATUS_*     : 2-bit status encodings presented to processor and host
//   DEF_*        : default address width, word width and implemented depth
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] STATUS_IDLE = 2'b00;
  localparam logic [1:0] STATUS_RUN  = 2'b01;
  localparam logic [1:0] STATUS_DONE = 2'b10;
  localparam logic [1:0] STATUS_ERR  = 2'b11;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/dm_responder_if.sv
// Signal bundle between the responder and its two clients.
//   Processor side : ar_in, bus_in, dm_en -> dm_out
//   Run control    : start, end_process -> status, done, err
//   Host side      : host_valid/we/addr/wdata -> host_ready, host_rdata, host_rvalid
// Modports: slave = responder, master = processor/host environment.
interface dm_responder_if #(
  parameter int ADDR_W = dm_pkg::DEF_ADDR_W,
  parameter int DATA_W = dm_pkg::DEF_DATA_W
);

  logic [ADDR_W-1:0] ar_in;
  logic [DATA_W-1:0] bus_in;
  logic              dm_en;
  logic [DATA_W-1:0] dm_out;
  logic [1:0]        status;
  logic              end_process;
  logic              start;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              done;
  logic              err;

  modport slave (
    input  ar_in, bus_in, dm_en, end_process, start,
    input  host_valid, host_we, host_addr, host_wdata,
    output dm_out, status, host_ready, host_rdata, host_rvalid, done, err
  );

  modport master (
    output ar_in, bus_in, dm_en, end_process, start,
    output host_valid, host_we, host_addr, host_wdata,
    input  dm_out, status, host_ready, host_rdata, host_rvalid, done, err
  );

endinterface

// File: rtl/dm_ram.sv
// Single-port data RAM with registered read and write-first behaviour.
//   clock    : rising-edge clock
//   en       : access this cycle (read register updates only when set)
//   we       : write enable, qualified by en
//   addr     : word address, checked against DEPTH
//   wdata    : write data
//   rdata    : registered read data (0 for out-of-range reads)
//   in_range : combinational, addr < DEPTH
module dm_ram #(
  parameter int ADDR_W = dm_pkg::DEF_ADDR_W,
  parameter int DATA_W = dm_pkg::DEF_DATA_W,
  parameter int DEPTH  = dm_pkg::DEF_DEPTH
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              in_range
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign in_range = (addr < ADDR_W'(DEPTH));
  assign idx      = addr[IDX_W-1:0];

  // Out-of-range accesses must not alias onto low words, so both the write
  // and the array read are gated by in_range.
  always_ff @(posedge clock) begin
    if (en) begin
      if (in_range) begin
        if (we) begin
          mem[idx] <= wdata;
          rdata    <= wdata;
        end else begin
          rdata    <= mem[idx];
        end
      end else begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: owns the data RAM, serves the processor's memory
// port while a run is active and a host port for preload/readback otherwise.
//   clock : rising-edge clock
//   rst_r : asynchronous active-low reset
//   bus   : dm_responder_if.slave (processor port, run control, host port)
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic           clock,
  input logic           rst_r,
  dm_responder_if.slave bus
);

  state_e state_q, state_d;

  logic              start_q;
  logic              start_rise;
  logic              run;
  logic              host_acc;
  logic              take_start;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_in_range;

  logic              proc_sel_p1;
  logic              host_rvalid_p1;
  logic              err_q;
  logic [DATA_W-1:0] dm_hold_p1;
  logic [DATA_W-1:0] host_hold_p1;

  // A held start must not relaunch a run, so runs are taken on its rising edge.
  assign start_rise = bus.start & ~start_q;
  assign run        = (state_q == ST_RUN);
  assign host_acc   = bus.host_valid & ~run;
  assign take_start = start_rise & ~run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_rise)      state_d = ST_RUN;
      ST_RUN:  if (bus.end_process) state_d = ST_DONE;
      ST_DONE: if (start_rise)      state_d = ST_RUN;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Processor owns the RAM during RUN and reads every cycle; the host owns
  // it otherwise and only touches it on an accepted request.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus.host_addr;
    ram_wdata = bus.host_wdata;
    if (run) begin
      ram_en    = 1'b1;
      ram_we    = bus.dm_en;
      ram_addr  = bus.ar_in;
      ram_wdata = bus.bus_in;
    end else if (host_acc) begin
      ram_en    = 1'b1;
      ram_we    = bus.host_we;
    end
  end

  dm_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock    (clock),
    .en       (ram_en),
    .we       (ram_we),
    .addr     (ram_addr),
    .wdata    (ram_wdata),
    .rdata    (ram_rdata),
    .in_range (ram_in_range)
  );

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
    end
  end

  // ---- stage p1: read owner and error tracking after the RAM edge ----
  // The shared read register is steered to whichever port issued the read;
  // each port keeps a hold copy so its output is stable once the other port
  // starts using the RAM.
  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      proc_sel_p1    <= 1'b0;
      host_rvalid_p1 <= 1'b0;
      err_q          <= 1'b0;
      dm_hold_p1     <= '0;
      host_hold_p1   <= '0;
    end else begin
      proc_sel_p1    <= run;
      host_rvalid_p1 <= host_acc & ~bus.host_we;
      // A fresh fault wins over the clear so no error is ever lost.
      if (ram_en && !ram_in_range) begin
        err_q <= 1'b1;
      end else if (take_start) begin
        err_q <= 1'b0;
      end
      if (proc_sel_p1) begin
        dm_hold_p1 <= ram_rdata;
      end
      if (host_rvalid_p1) begin
        host_hold_p1 <= ram_rdata;
      end
    end
  end

  assign bus.dm_out      = proc_sel_p1    ? ram_rdata : dm_hold_p1;
  assign bus.host_rdata  = host_rvalid_p1 ? ram_rdata : host_hold_p1;
  assign bus.host_rvalid = host_rvalid_p1;
  assign bus.host_ready  = host_acc;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err         = err_q;

  always_comb begin
    if (run) begin
      bus.status = STATUS_RUN;
    end else if (err_q) begin
      bus.status = STATUS_ERR;
    end else if (state_q == ST_DONE) begin
      bus.status = STATUS_DONE;
    end else begin
      bus.status = STATUS_IDLE;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic clock;
  logic rst_r;

  dm_responder_if #(.ADDR_W(16), .DATA_W(8)) ifc ();

  dm_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(1024)) dut (
    .clock (clock),
    .rst_r (rst_r),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [$];

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Host read data is checked against the scoreboard whenever rvalid shows.
  always @(negedge clock) begin
    if (ifc.host_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL host_rvalid_unexpected: got 1 expected 0");
      end else begin
        chk("host_rdata", {24'd0, ifc.host_rdata}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic host_op(input bit we, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp);
    ifc.host_valid = 1'b1;
    ifc.host_we    = we;
    ifc.host_addr  = addr;
    ifc.host_wdata = wdata;
    #1;
    chk("host_ready", {31'd0, ifc.host_ready}, 32'd1);
    if (!we) sb.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  task automatic host_idle();
    ifc.host_valid = 1'b0;
    ifc.host_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0000, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 16'h0001, 8'h22, 8'h00};
    vecs[2] = '{1'b1, 16'h0002, 8'h33, 8'h00};
    vecs[3] = '{1'b0, 16'h0001, 8'h00, 8'h22};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 8'h11};
    vecs[5] = '{1'b0, 16'h0002, 8'h00, 8'h33};
    vecs[6] = '{1'b1, 16'h03FF, 8'h5A, 8'h00};
    vecs[7] = '{1'b0, 16'h03FF, 8'h00, 8'h5A};
    vecs[8] = '{1'b1, 16'h0003, 8'hC3, 8'h00};
    vecs[9] = '{1'b0, 16'h0003, 8'h00, 8'hC3};

    rst_r           = 1'b0;
    ifc.ar_in       = '0;
    ifc.bus_in      = '0;
    ifc.dm_en       = 1'b0;
    ifc.end_process = 1'b0;
    ifc.start       = 1'b0;
    ifc.host_valid  = 1'b0;
    ifc.host_we     = 1'b0;
    ifc.host_addr   = '0;
    ifc.host_wdata  = '0;
    tick();
    tick();

    // Reset state
    chk("rst_status", {30'd0, ifc.status}, 32'd0);
    chk("rst_dm_out", {24'd0, ifc.dm_out}, 32'd0);
    chk("rst_rvalid", {31'd0, ifc.host_rvalid}, 32'd0);
    chk("rst_ready", {31'd0, ifc.host_ready}, 32'd0);
    chk("rst_done", {31'd0, ifc.done}, 32'd0);
    chk("rst_err", {31'd0, ifc.err}, 32'd0);
    chk("rst_rdata", {24'd0, ifc.host_rdata}, 32'd0);
    rst_r = 1'b1;
    tick();

    // Host preload / readback, back-to-back
    for (int i = 0; i < 10; i++) begin
      host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      chk("idle_status", {30'd0, ifc.status}, 32'd0);
    end
    host_idle();
    tick();
    chk("rvalid_one_cycle", {31'd0, ifc.host_rvalid}, 32'd0);
    chk("rdata_hold", {24'd0, ifc.host_rdata}, 32'hC3);

    // Start a run; host stalls with no side effects
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("run_status", {30'd0, ifc.status}, 32'd1);
    ifc.host_valid = 1'b1;
    ifc.host_we    = 1'b1;
    ifc.host_addr  = 16'h0000;
    ifc.host_wdata = 8'hEE;
    #1;
    chk("run_host_ready", {31'd0, ifc.host_ready}, 32'd0);
    ifc.ar_in = 16'h0002;
    tick();
    ifc.host_we = 1'b0;
    tick();
    host_idle();
    chk("run_dm_out_addr2", {24'd0, ifc.dm_out}, 32'h33);
    chk("run_no_rvalid", {31'd0, ifc.host_rvalid}, 32'd0);

    // Write-first read of the same address
    ifc.ar_in  = 16'h0005;
    ifc.bus_in = 8'hA5;
    ifc.dm_en  = 1'b1;
    tick();
    ifc.dm_en = 1'b0;
    chk("write_first", {24'd0, ifc.dm_out}, 32'hA5);
    ifc.end_process = 1'b1;
    tick();
    ifc.end_process = 1'b0;
    chk("done_status", {30'd0, ifc.status}, 32'd2);
    chk("done_flag", {31'd0, ifc.done}, 32'd1);

    // dm_en ignored outside RUN; dm_out holds across host traffic
    ifc.ar_in  = 16'h0000;
    ifc.bus_in = 8'h77;
    ifc.dm_en  = 1'b1;
    tick();
    ifc.dm_en = 1'b0;
    host_op(1'b0, 16'h0005, 8'h00, 8'hA5);
    host_op(1'b0, 16'h0000, 8'h00, 8'h11);
    host_op(1'b0, 16'h0002, 8'h00, 8'h33);
    host_idle();
    tick();
    chk("dm_out_hold", {24'd0, ifc.dm_out}, 32'hA5);

    // Out-of-range processor write
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.ar_in  = 16'h0400;
    ifc.bus_in = 8'hFF;
    ifc.dm_en  = 1'b1;
    tick();
    ifc.dm_en = 1'b0;
    ifc.ar_in = 16'h0000;
    chk("oor_err", {31'd0, ifc.err}, 32'd1);
    chk("oor_read_zero", {24'd0, ifc.dm_out}, 32'd0);
    chk("oor_run_status", {30'd0, ifc.status}, 32'd1);
    ifc.end_process = 1'b1;
    tick();
    ifc.end_process = 1'b0;
    chk("err_status", {30'd0, ifc.status}, 32'd3);
    host_op(1'b0, 16'h0400, 8'h00, 8'h00);
    host_op(1'b0, 16'h0000, 8'h00, 8'h11);
    host_idle();
    tick();

    // Start clears err; start held high through DONE does not relaunch
    ifc.start = 1'b1;
    tick();
    chk("start_clears_err", {31'd0, ifc.err}, 32'd0);
    chk("rerun_status", {30'd0, ifc.status}, 32'd1);
    ifc.end_process = 1'b1;
    tick();
    ifc.end_process = 1'b0;
    tick();
    tick();
    chk("held_start_stays_done", {30'd0, ifc.status}, 32'd2);
    ifc.start = 1'b0;
    tick();
    chk("release_start_done", {30'd0, ifc.status}, 32'd2);

    // Back to IDLE; start with end_process in the same cycle
    rst_r = 1'b0;
    tick();
    rst_r = 1'b1;
    tick();
    chk("idle_again", {30'd0, ifc.status}, 32'd0);
    ifc.start       = 1'b1;
    ifc.end_process = 1'b1;
    tick();
    ifc.start       = 1'b0;
    ifc.end_process = 1'b0;
    chk("start_end_run", {30'd0, ifc.status}, 32'd1);
    tick();
    chk("stays_run", {30'd0, ifc.status}, 32'd1);
    ifc.end_process = 1'b1;
    tick();
    ifc.end_process = 1'b0;
    chk("then_done", {30'd0, ifc.status}, 32'd2);

    // Asynchronous reset mid-RUN
    ifc.start = 1'b1;
    tick();
    ifc.start  = 1'b0;
    ifc.ar_in  = 16'h0006;
    ifc.bus_in = 8'h6C;
    ifc.dm_en  = 1'b1;
    tick();
    ifc.dm_en = 1'b0;
    chk("pre_reset_dm_out", {24'd0, ifc.dm_out}, 32'h6C);
    #2;
    rst_r = 1'b0;
    #1;
    chk("async_status", {30'd0, ifc.status}, 32'd0);
    chk("async_dm_out", {24'd0, ifc.dm_out}, 32'd0);
    chk("async_done", {31'd0, ifc.done}, 32'd0);
    tick();
    rst_r = 1'b1;
    ifc.ar_in = 16'h0000;
    tick();
    ifc.host_valid = 1'b1;
    #1;
    chk("post_reset_ready", {31'd0, ifc.host_ready}, 32'd1);
    host_idle();
    tick();
    tick();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
